diff_comb: RTL and testbench

DIFF_COMB -- requirements
Module: diff_comb

---
 rtl/pll_pkg.sv | 15 +
 rtl/comb_hist.sv | 29 ++
 rtl/diff_comb.sv | 86 ++++++++
 tb/tb_diff_comb.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared sample-path definitions for the CIC comb stage.
package pll_pkg;

  // Integrator word width; diff_comb must match it to invert the wrap exactly.
  localparam int unsigned N_DEFAULT = 24;

  // Deepest differential delay the comb history supports.
  localparam int unsigned M_MAX = 8;

  // Holds a prime count of 0..M_MAX.
  localparam int unsigned PRIME_W = $clog2(M_MAX + 1);

  typedef logic signed [N_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/comb_hist.sv
// M-deep history of accepted samples; tap is the sample M transfers ago.
module comb_hist
  import pll_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned M = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic signed [N-1:0] d,
  output logic signed [N-1:0] tap
);

  logic signed [N-1:0] h_q [M];

  // Shift in a new sample only on an accepted input; hold otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < M; k++) h_q[k] <= '0;
    end else if (en) begin
      h_q[0] <= d;
      for (int unsigned k = 1; k < M; k++) h_q[k] <= h_q[k-1];
    end
  end

  assign tap = h_q[M-1];

endmodule

// File: rtl/diff_comb.sv
// CIC comb stage: Out = I - I[n-M], wrapping modulo 2^N, with valid/ready
// handshake on both sides and one-cycle registered latency.
// Optional macro DIFF_COMB_PRIME_EN suppresses results until the history
// holds M real samples.
module diff_comb
  import pll_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned M = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic signed [N-1:0] I,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [N-1:0] Out,
  output logic                out_valid,
  input  logic                out_ready
);

  logic signed [N-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic signed [N-1:0] tap;
  logic                xfer_in;
  logic                produce;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer_in  = in_valid && in_ready;

  comb_hist #(.N(N), .M(M)) u_hist (
    .CLK (CLK),
    .RST (RST),
    .en  (xfer_in),
    .d   (I),
    .tap (tap)
  );

`ifdef DIFF_COMB_PRIME_EN
  logic [PRIME_W-1:0] prime_q, prime_d;

  // Results begin only once the history is full of post-reset samples.
  always_comb begin
    prime_d = prime_q;
    produce = 1'b0;
    if (xfer_in) begin
      if (prime_q < PRIME_W'(M)) prime_d = prime_q + 1'b1;
      else                       produce = 1'b1;
    end
  end

  // Saturating count of accepted samples since reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) prime_q <= '0;
    else     prime_q <= prime_d;
  end
`else
  assign produce = xfer_in;
`endif

  // Load a new difference on a producing transfer; drop valid once consumed.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (produce) begin
      out_d       = I - tap;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_diff_comb.sv
// Directed bench for diff_comb; expectations follow DIFF_COMB_PRIME_EN.
module tb_diff_comb;
  import pll_pkg::*;

  logic    CLK = 1'b0;
  logic    RST = 1'b1;

  // M = 1 instance
  sample_t I1 = '0;
  logic    iv1 = 1'b0, ir1, ov1, or1 = 1'b1;
  sample_t O1;

  // M = 2 instance
  sample_t I2 = '0;
  logic    iv2 = 1'b0, ir2, ov2, or2 = 1'b1;
  sample_t O2;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 CLK = ~CLK;

  diff_comb #(.N(24), .M(1)) dut1 (
    .CLK(CLK), .RST(RST), .I(I1), .in_valid(iv1), .in_ready(ir1),
    .Out(O1), .out_valid(ov1), .out_ready(or1)
  );

  diff_comb #(.N(24), .M(2)) dut2 (
    .CLK(CLK), .RST(RST), .I(I2), .in_valid(iv2), .in_ready(ir2),
    .Out(O2), .out_valid(ov2), .out_ready(or2)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one sample to dut1 and move to 1 time unit after the edge.
  task automatic s1(input logic [23:0] x);
    I1  = x;
    iv1 = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic s2(input logic [23:0] x);
    I2  = x;
    iv2 = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  logic [23:0] x, acc;
  bit prime;

  initial begin
`ifdef DIFF_COMB_PRIME_EN
    prime = 1'b1;
`else
    prime = 1'b0;
`endif
    // Reset state
    #2;
    chk("rst_out", O1, 24'h0);
    chk("rst_valid", {23'h0, ov1}, 24'h0);
    chk("rst_in_ready", {23'h0, ir1}, 24'h1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst_in_ready", {23'h0, ir1}, 24'h1);

    // Basic stream 5,7,7,-2 at M=1
    s1(24'd5);
    chk("s5_valid", {23'h0, ov1}, prime ? 24'h0 : 24'h1);
    chk("s5_out", O1, prime ? 24'h0 : 24'd5);
    s1(24'd7);
    chk("s7_valid", {23'h0, ov1}, 24'h1);
    chk("s7_out", O1, 24'd2);
    s1(24'd7);
    chk("s7b_out", O1, 24'd0);
    s1(24'hFFFFFE);
    chk("sm2_out", O1, 24'hFFFFF7);
    iv1 = 1'b0;
    @(posedge CLK);
    #1;
    chk("drain_valid", {23'h0, ov1}, 24'h0);
    chk("drain_hold_out", O1, 24'hFFFFF7);

    // Wrap: H=-2, then 0x7FFFFF, 0x800001
    s1(24'h7FFFFF);
    chk("wrap1_out", O1, 24'h800001);
    s1(24'h800001);
    chk("wrap2_out", O1, 24'h000002);

    // Backpressure for 3 cycles with a pending sample of 50
    or1 = 1'b0;
    I1  = 24'd50;
    iv1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk("bp_in_ready", {23'h0, ir1}, 24'h0);
      chk("bp_out", O1, 24'h000002);
      chk("bp_valid", {23'h0, ov1}, 24'h1);
    end
    or1 = 1'b1;
    #1;
    chk("bp_release_ready", {23'h0, ir1}, 24'h1);
    @(posedge CLK);
    #1;
    chk("bp_resume_out", O1, 24'h800031);
    s1(24'd60);
    chk("bp_next_out", O1, 24'd10);

    // Integrator round trip; history currently holds 60
    acc = 24'd60;
    for (int i = 0; i < 1000; i++) begin
      x   = 24'($urandom);
      acc = acc + x;
      s1(acc);
      chk("roundtrip", O1, x);
    end
    chk("rt_valid", {23'h0, ov1}, 24'h1);

    // Asynchronous reset mid-stream with out_valid=1
    iv1 = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("arst_valid", {23'h0, ov1}, 24'h0);
    chk("arst_out", O1, 24'h0);
    chk("arst_in_ready", {23'h0, ir1}, 24'h1);
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    s1(24'd123);
    chk("arst_first_valid", {23'h0, ov1}, prime ? 24'h0 : 24'h1);
    chk("arst_first_out", O1, prime ? 24'h0 : 24'd123);
    s1(24'd200);
    chk("arst_second_out", O1, 24'd77);
    iv1 = 1'b0;

    // M=2: 10,20,35,55
    s2(24'd10);
    chk("m2_s0_valid", {23'h0, ov2}, prime ? 24'h0 : 24'h1);
    chk("m2_s0_out", O2, prime ? 24'h0 : 24'd10);
    s2(24'd20);
    chk("m2_s1_valid", {23'h0, ov2}, prime ? 24'h0 : 24'h1);
    chk("m2_s1_out", O2, prime ? 24'h0 : 24'd20);
    s2(24'd35);
    chk("m2_s2_valid", {23'h0, ov2}, 24'h1);
    chk("m2_s2_out", O2, 24'd25);
    s2(24'd55);
    chk("m2_s3_out", O2, 24'd35);
    iv2 = 1'b0;
    @(posedge CLK);
    #1;
    chk("m2_drain_valid", {23'h0, ov2}, 24'h0);
    // Idle cycle must not disturb history: next diff is against 35
    s2(24'd100);
    chk("m2_after_idle_out", O2, 24'd65);
    iv2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
